// File: rtl/program_fetch.sv
// Instruction fetch stage: owns the program memory, walks the pc from address 0
// on i_start and issues one instruction per enabled cycle until the halt opcode.
module program_fetch #(
    parameter int                    NB_INSTRUC  = 16,
    parameter int                    NB_OPCODE   = 5,
    parameter int                    NB_ADDR     = 11,
    parameter logic [NB_OPCODE-1:0]  HALT_OPCODE = 5'b00000
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_enable,
    input  logic                  i_prog_we,
    input  logic [NB_ADDR-1:0]    i_prog_addr,
    input  logic [NB_INSTRUC-1:0] i_prog_data,
    output logic [NB_INSTRUC-1:0] o_instruc,
    output logic [NB_ADDR-1:0]    o_pc,
    output logic                  o_valid,
    output logic                  o_halt,
    output logic                  o_busy
);

    localparam int DEPTH = 2 ** NB_ADDR;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [NB_ADDR-1:0]      pc_q, pc_d;
    logic [NB_INSTRUC-1:0]   instruc_q, instruc_d;
    logic [NB_ADDR-1:0]      opc_q, opc_d;
    logic                    valid_q, valid_d;

    logic [NB_INSTRUC-1:0]   mem [0:DEPTH-1];
    logic [NB_INSTRUC-1:0]   rd_data_q;
    logic [NB_ADDR-1:0]      rd_addr;
    logic                    mem_we;
    logic                    is_halt;

    // The RAM is read one cycle ahead at the next pc, so rd_data_q always
    // holds mem[pc_q] when the fetch decision is made.
    assign rd_addr = i_rst ? '0 : pc_d;
    assign mem_we  = i_prog_we && !i_rst && (state_q != ST_RUN);
    assign is_halt = (rd_data_q[NB_INSTRUC-1 -: NB_OPCODE] == HALT_OPCODE);

    // NOTE: the memory array has no reset; clearing it would prevent block-RAM
    // inference and its contents must survive i_rst anyway.
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem[i_prog_addr] <= i_prog_data;
        end
        // Write-first forwarding so a write on the start edge reaches the first fetch.
        if (mem_we && (i_prog_addr == rd_addr)) begin
            rd_data_q <= i_prog_data;
        end else begin
            rd_data_q <= mem[rd_addr];
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case can leave a value unassigned and infer a latch.
        state_d   = state_q;
        pc_d      = pc_q;
        instruc_d = instruc_q;
        opc_d     = opc_q;
        valid_d   = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_HALT: begin
                if (i_start) begin
                    state_d = ST_RUN;
                    pc_d    = '0;
                end
            end
            ST_RUN: begin
                if (i_enable) begin
                    if (is_halt) begin
                        state_d = ST_HALT;
                    end else begin
                        instruc_d = rd_data_q;
                        opc_d     = pc_q;
                        valid_d   = 1'b1;
                        pc_d      = pc_q + NB_ADDR'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                pc_d    = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            instruc_q <= '0;
            opc_q     <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instruc_q <= instruc_d;
            opc_q     <= opc_d;
            valid_q   <= valid_d;
        end
    end

    assign o_instruc = instruc_q;
    assign o_pc      = opc_q;
    assign o_valid   = valid_q;
    assign o_halt    = (state_q == ST_HALT);
    assign o_busy    = (state_q == ST_RUN);

endmodule

// File: tb/tb_program_fetch.sv
// Directed bench for program_fetch: hand-computed expectations for fetch order,
// stalls, halt/restart, write blocking, reset abort and pc wrap.
module tb_program_fetch;

    logic        i_clk;
    logic        i_rst;
    logic        i_start;
    logic        i_enable;
    logic        i_prog_we;
    logic [10:0] i_prog_addr;
    logic [15:0] i_prog_data;
    logic [15:0] o_instruc;
    logic [10:0] o_pc;
    logic        o_valid;
    logic        o_halt;
    logic        o_busy;

    int total;
    int bad;

    program_fetch dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .i_enable    (i_enable),
        .i_prog_we   (i_prog_we),
        .i_prog_addr (i_prog_addr),
        .i_prog_data (i_prog_data),
        .o_instruc   (o_instruc),
        .o_pc        (o_pc),
        .o_valid     (o_valid),
        .o_halt      (o_halt),
        .o_busy      (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_mem(input logic [10:0] addr, input logic [15:0] data);
        i_prog_we   = 1'b1;
        i_prog_addr = addr;
        i_prog_data = data;
        tick();
        i_prog_we   = 1'b0;
    endtask

    task automatic check_issue(input string tag, input logic [15:0] ins, input logic [10:0] pc);
        check({tag, "_valid"}, 32'(o_valid), 32'd1);
        check({tag, "_instruc"}, 32'(o_instruc), 32'(ins));
        check({tag, "_pc"}, 32'(o_pc), 32'(pc));
    endtask

    task automatic check_halted(input string tag, input logic [10:0] pc);
        check({tag, "_halt"}, 32'(o_halt), 32'd1);
        check({tag, "_valid"}, 32'(o_valid), 32'd0);
        check({tag, "_busy"}, 32'(o_busy), 32'd0);
        check({tag, "_pc"}, 32'(o_pc), 32'(pc));
    endtask

    task automatic start_pulse();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    initial begin
        int invalid_cnt;
        total       = 0;
        bad         = 0;
        i_rst       = 1'b1;
        i_start     = 1'b0;
        i_enable    = 1'b0;
        i_prog_we   = 1'b0;
        i_prog_addr = '0;
        i_prog_data = '0;

        // Reset state
        tick();
        tick();
        check("rst_instruc", 32'(o_instruc), 32'd0);
        check("rst_pc", 32'(o_pc), 32'd0);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_halt", 32'(o_halt), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        i_rst = 1'b0;

        // Load program in IDLE
        write_mem(11'd0, 16'h0801);
        write_mem(11'd1, 16'h1002);
        write_mem(11'd2, 16'h0000);
        write_mem(11'd3, 16'h0000);
        check("idle_valid", 32'(o_valid), 32'd0);
        check("idle_busy", 32'(o_busy), 32'd0);

        // Basic run: two instructions then halt at pc 1
        i_enable = 1'b1;
        start_pulse();
        check("run_entry_busy", 32'(o_busy), 32'd1);
        check("run_entry_valid", 32'(o_valid), 32'd0);
        tick();
        check_issue("run_i0", 16'h0801, 11'd0);
        i_start = 1'b1;  // ignored in RUN
        tick();
        i_start = 1'b0;
        check_issue("run_i1", 16'h1002, 11'd1);
        tick();
        check_halted("run_halt", 11'd1);
        check("run_halt_instruc", 32'(o_instruc), 32'h1002);
        tick();
        check_halted("run_halt_hold", 11'd1);

        // Stall for 3 cycles after the first instruction
        start_pulse();
        check("stall_entry_halt", 32'(o_halt), 32'd0);
        check("stall_entry_busy", 32'(o_busy), 32'd1);
        tick();
        check_issue("stall_i0", 16'h0801, 11'd0);
        i_enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_valid", 32'(o_valid), 32'd0);
            check("stall_pc", 32'(o_pc), 32'd0);
            check("stall_instruc", 32'(o_instruc), 32'h0801);
            check("stall_busy", 32'(o_busy), 32'd1);
        end
        i_enable = 1'b1;
        tick();
        check_issue("stall_i1", 16'h1002, 11'd1);
        tick();
        check_halted("stall_halt", 11'd1);

        // Program write during RUN is ignored
        start_pulse();
        tick();
        check_issue("wrun_i0", 16'h0801, 11'd0);
        i_prog_we   = 1'b1;
        i_prog_addr = 11'd1;
        i_prog_data = 16'hFFFF;
        tick();
        i_prog_we   = 1'b0;
        check_issue("wrun_i1", 16'h1002, 11'd1);
        tick();
        check_halted("wrun_halt", 11'd1);

        // Reset mid-RUN with coincident start and write: reset wins
        start_pulse();
        tick();
        tick();
        check_issue("rrun_i1", 16'h1002, 11'd1);
        i_rst       = 1'b1;
        i_start     = 1'b1;
        i_prog_we   = 1'b1;
        i_prog_addr = 11'd0;
        i_prog_data = 16'hFFFF;
        tick();
        i_rst     = 1'b0;
        i_start   = 1'b0;
        i_prog_we = 1'b0;
        check("rrun_instruc", 32'(o_instruc), 32'd0);
        check("rrun_pc", 32'(o_pc), 32'd0);
        check("rrun_valid", 32'(o_valid), 32'd0);
        check("rrun_halt", 32'(o_halt), 32'd0);
        check("rrun_busy", 32'(o_busy), 32'd0);
        tick();
        tick();
        check("rrun_no_valid", 32'(o_valid), 32'd0);
        check("rrun_still_idle", 32'(o_busy), 32'd0);
        start_pulse();
        tick();
        check_issue("rrun_re_i0", 16'h0801, 11'd0);
        tick();
        check_issue("rrun_re_i1", 16'h1002, 11'd1);
        tick();
        check_halted("rrun_re_halt", 11'd1);

        // Write mem[2] with start on the same edge in HALT
        i_prog_we   = 1'b1;
        i_prog_addr = 11'd2;
        i_prog_data = 16'h1803;
        i_start     = 1'b1;
        tick();
        i_prog_we = 1'b0;
        i_start   = 1'b0;
        check("hws_halt_clr", 32'(o_halt), 32'd0);
        check("hws_busy", 32'(o_busy), 32'd1);
        tick();
        check_issue("hws_i0", 16'h0801, 11'd0);
        tick();
        check_issue("hws_i1", 16'h1002, 11'd1);
        tick();
        check_issue("hws_i2", 16'h1803, 11'd2);
        tick();
        check_halted("hws_halt", 11'd2);

        // Write to address 0 on the start edge must reach the very first fetch
        i_prog_we   = 1'b1;
        i_prog_addr = 11'd0;
        i_prog_data = 16'h1804;
        i_start     = 1'b1;
        tick();
        i_prog_we = 1'b0;
        i_start   = 1'b0;
        tick();
        check_issue("fwd_i0", 16'h1804, 11'd0);

        // Fill every word with a non-halting instruction and run across the wrap
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        for (int a = 0; a < 2048; a++) begin
            write_mem(11'(a), 16'h0801);
        end
        start_pulse();
        invalid_cnt = 0;
        for (int k = 1; k <= 2050; k++) begin
            tick();
            if (o_valid !== 1'b1) invalid_cnt++;
            if (k == 2047) check("wrap_pc_2046", 32'(o_pc), 32'd2046);
            if (k == 2048) check("wrap_pc_2047", 32'(o_pc), 32'd2047);
            if (k == 2049) check("wrap_pc_0", 32'(o_pc), 32'd0);
            if (k == 2050) check("wrap_pc_1", 32'(o_pc), 32'd1);
        end
        check("wrap_valid_drops", 32'(invalid_cnt), 32'd0);
        check("wrap_busy", 32'(o_busy), 32'd1);
        check("wrap_halt", 32'(o_halt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
